// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM state
// encoding, mem_size codes and width constants.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned CNT_W      = 3;

   // Number of bytes moved for a mem_size code; 11 is treated as a word.
   function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = CNT_W'(1);
         SZ_HALF: size_bytes = CNT_W'(2);
         default: size_bytes = CNT_W'(WORD_BYTES);
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetches and
// data loads/stores onto a single 8-bit RAM port (one-cycle read latency).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [7:0]        ram_din,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_inst,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_len;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_is_fetch;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_data;

   logic               w_active;
   logic               w_abort;

   // RAM port is live only while the counter is still issuing addresses.
   assign w_active = ((r_state == RD) || (r_state == WR)) && (r_cnt < r_len);
   // A fetch whose requester went away is dropped; data accesses never are.
   assign w_abort  = (r_state == RD) && r_is_fetch && !if_req;

   // Transfer FSM: arbitration, byte counting and read-data assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_len      <= '0;
         r_addr     <= '0;
         r_is_fetch <= 1'b0;
         r_wdata    <= '0;
         r_data     <= '0;
      end else if (rdy) begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (mem_req) begin
                  r_addr     <= mem_addr;
                  r_len      <= size_bytes(mem_size);
                  r_is_fetch <= 1'b0;
                  r_wdata    <= mem_wdata;
                  r_data     <= '0;
                  r_state    <= mem_we ? WR : RD;
               end else if (if_req) begin
                  r_addr     <= if_addr;
                  r_len      <= CNT_W'(WORD_BYTES);
                  r_is_fetch <= 1'b1;
                  r_data     <= '0;
                  r_state    <= RD;
               end
            end
            RD: begin
               if (w_abort) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  // ram_din carries the byte addressed in the previous cycle.
                  if (r_cnt != '0)
                     r_data[(int'(r_cnt) - 1) * BYTE_W +: BYTE_W] <= ram_din;
                  if (r_cnt == r_len)
                     r_state <= DONE;
                  else
                     r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            WR: begin
               if (r_cnt == r_len - CNT_W'(1))
                  r_state <= DONE;
               else
                  r_cnt <= r_cnt + CNT_W'(1);
            end
            DONE: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // RAM port drive decoded from state; write strobe is gated by rdy.
   always_comb begin
      ram_a    = '0;
      ram_dout = '0;
      ram_wr   = 1'b0;
      if (w_active) begin
         ram_a = r_addr + ADDR_W'(r_cnt);
         if (r_state == WR) begin
            ram_dout = r_wdata[int'(r_cnt) * BYTE_W +: BYTE_W];
            ram_wr   = rdy;
         end
      end
   end

   assign if_done   = (r_state == DONE) && r_is_fetch && rdy;
   assign mem_done  = (r_state == DONE) && !r_is_fetch && rdy;
   assign if_inst   = r_data;
   assign mem_rdata = r_data;
   assign stall_if  = if_req & ~if_done;
   assign stall_mem = mem_req & ~mem_done;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W default 32, CPU address width; DATA_W default 32, CPU data width.
REQ-002 SHALL use one clock and a synchronous, active-high reset. Clock port is clk; reset port is rst.
REQ-003 Ports: clk  in  1  rising-edge clock.
REQ-004 Ports: rst  in  1  synchronous active-high reset.
REQ-005 Ports: rdy  in  1  global ready; low freezes the block.
REQ-006 Ports: if_req  in  1  instruction fetch request, held until if_done.
REQ-007 Ports: if_addr  in  ADDR_W  fetch address, stable while if_req.
REQ-008 Ports: mem_req  in  1  load/store request, held until mem_done.
REQ-009 Ports: mem_we  in  1  1=store, 0=load.
REQ-010 Ports: mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 Ports: mem_addr  in  ADDR_W  load/store address.
REQ-012 Ports: mem_wdata  in  DATA_W  store data, little-endian, low bytes used.
REQ-013 Ports: ram_din  in  8  byte from RAM, valid one cycle after ram_a.
REQ-014 Ports: ram_a  out  ADDR_W  RAM byte address.
REQ-015 Ports: ram_dout  out  8  byte to RAM.
REQ-016 Ports: ram_wr  out  1  RAM write strobe.
REQ-017 Ports: if_done, if_inst  out  1, DATA_W  one-cycle completion pulse and fetched word.
REQ-018 Ports: mem_done, mem_rdata  out  1, DATA_W  one-cycle completion pulse and zero-extended load data.
REQ-019 Ports: stall_if, stall_mem  out  1, 1  combinational: if_req & ~if_done; mem_req & ~mem_done. These feed the stall bus.

Function
REQ-020 FSM states SHALL be: IDLE, RD, WR, DONE.
REQ-021 IDLE arbitration: mem_req beats if_req. Winner's address, size and we SHALL be latched. Fetch is always 4 bytes.
REQ-022 RD: in the cycle with counter k < N, ram_a SHALL be addr+k. The byte at ram_din in the cycle with counter k ≥ 1 SHALL be stored as byte k-1. After byte N-1 is stored, the FSM SHALL move to DONE.
REQ-023 WR: in the cycle with counter k < N, ram_wr=1, ram_a=addr+k and ram_dout=wdata byte k. After k=N-1, the FSM SHALL move to DONE.
REQ-024 DONE: the FSM SHALL pulse exactly one of if_done or mem_done for one cycle, with data valid in that same cycle, then return to IDLE. Requests are not sampled in DONE.
REQ-025 Latency from the first request cycle to the done pulse: word read 6 cycles; byte read 3 cycles; word write 5 cycles; byte write 2 cycles.
REQ-026 In IDLE and DONE: ram_wr=0 and ram_a=0.
REQ-027 Fetch abort: if if_req drops while a fetch is in RD, the FSM SHALL go to IDLE next cycle with no if_done. Data loads/stores are never aborted.
REQ-028 rdy=0: state, counter and data registers SHALL hold; ram_wr SHALL be forced 0; done outputs SHALL be 0. When rdy returns high, operation SHALL resume from where it stopped.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; 0xFFFFFFFF+1 wraps to 0.
REQ-030 When if_req and mem_req are both high in IDLE, mem SHALL be served first. The fetch SHALL start in the IDLE that follows mem's DONE.

Reset
REQ-031 On rst=1 at a clock edge, regardless of rdy: state=IDLE, counter=0, and all output registers 0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no done pulse. ram_wr SHALL be 0 from the next cycle.

Structure
REQ-033 Shared package SHALL hold the state encoding, the mem_size codes and the width constants.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Fetch if_addr=0x100, RAM bytes 13 05 00 00:
- ram_a sequence 0x100..0x103;
- if_done in cycle 6 with if_inst=0x00000513.
REQ-036 Simultaneous if_req and mem_req (load word at 0x200):
- mem_done precedes if_done;
- stall_if stays high throughout.
REQ-037 Store half 0xBEEF at 0x1000:
- ram_wr=1 for 2 cycles, writing 0xEF to 0x1000 then 0xBE to 0x1001;
- mem_done in cycle 3.
REQ-038 if_req dropped during the third byte of a fetch:
- no if_done;
- IDLE next cycle;
- next mem_req served normally.
REQ-039 rdy=0 for 3 cycles mid word-load:
- ram_wr stays 0;
- result is identical to the run without the stall, delayed by 3 cycles.
REQ-040 rst during WR at byte 1:
- ram_wr=0 in the next cycle;
- no mem_done;
- all outputs 0.
